adc_pattern_check: RTL
======================

// Module: adc_pattern_check
// PURPOSE
// - Consumer of the check-interval `enable` level from the ADC input-test sequencer.
// - While `enable` is high, compares each ADC sample to an expected test pattern and counts words and mismatches.
// - Publishes a latched verdict when the interval ends; firmware reads it to qualify ADC link/deskew settings.
// PARAMETERS
// - DATA_W     12       ADC sample width
// - ERR_W      16       mismatch counter width; saturating
// - WCNT_W     32       checked-word counter width; saturating
// - FIXED_PAT  12'hA5A  expected word for pattern_sel 0/3 (DATA_W bits)
// PORTS
// - clk          in   1       system clock; all logic on posedge
// - rst_n        in   1       asynchronous, active-low reset
// - enable       in   1       check-interval level from sequencer
// - pattern_sel  in   2       0 fixed, 1 ramp, 2 toggle, 3 = fixed; sampled at interval start
// - adc_data     in   DATA_W  ADC sample, valid every clk
// - busy         out  1       interval in progress (SYNC or CHECK)
// - done         out  1       one-cycle pulse at interval end
// - pass         out  1       latched: err_cnt==0 and word_cnt!=0
// - err_cnt      out  ERR_W   mismatches in last/current interval
// - word_cnt     out  WCNT_W  words compared in last/current interval
// - bad_bits     out  DATA_W  OR of (data ^ expected); see CONFIGURATION
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; input registers 0.
// - Input stage: enable and adc_data registered once (en_r, d_r). All decisions use en_r/d_r, so response lags pins by 1 clk.
// - FSM IDLE -> SYNC -> CHECK -> DONE -> IDLE.
// - IDLE: en_r rising edge (en_r=1, previous en_r=0) -> latch pattern_sel; clear err_cnt, word_cnt, bad_bits, pass; busy<=1; go SYNC.
// - SYNC, one cycle, en_r=1: seed the expected value.
//   - fixed: compare d_r to FIXED_PAT now (word_cnt becomes 1, err_cnt 0 or 1); exp stays FIXED_PAT.
//   - ramp: no compare; exp <= d_r+1 mod 2^DATA_W.
//   - toggle: no compare; exp <= ~d_r.
//   - Then go CHECK.
// - CHECK, each cycle with en_r=1:
//   - compare d_r to exp; word_cnt+1; mismatch -> err_cnt+1.
//   - exp advances from exp, not from d_r: ramp exp+1 (wraps 2^DATA_W-1 -> 0), toggle ~exp, fixed unchanged.
//   - A single corrupted sample therefore costs exactly 1 error; a slip gives persistent errors.
// - en_r=0 in SYNC or CHECK -> DONE. In DONE: done=1 for that cycle, pass <= (err_cnt==0 && word_cnt!=0), busy<=0 -> IDLE.
// - Counters saturate at all-ones, never wrap. err_cnt saturated implies pass=0.
// - err_cnt, word_cnt, bad_bits and pass hold after DONE until the next interval start.
// - Interval of one en_r cycle (SYNC only): fixed pattern -> word_cnt 1; ramp/toggle -> word_cnt 0, pass 0.
// - en_r re-rises in the DONE cycle: ignored. It is honoured only when IDLE sees a rising edge, so a level held high across DONE does not restart.
// - pattern_sel changes mid-interval: ignored.
// - rst_n low mid-interval: immediate return to IDLE, outputs 0, no done pulse.
// CONFIGURATION
// - BITMASK_EN defined:
//   - bad_bits accumulates OR of (d_r ^ exp) over every compared word of the interval.
//   - Cleared at interval start; held after DONE.
// - BITMASK_EN undefined: bad_bits tied to 0; no accumulation logic generated.
// TESTING
// - Fixed 12'hA5A for 100 clks in window -> word_cnt=100, err_cnt=0, pass=1, one done pulse 2 clks after enable falls.
// - Ramp 0xFFD..0xFFF,0x000.. for 50 words -> wrap accepted; word_cnt=49, err_cnt=0, pass=1.
// - Ramp with one sample forced to 0x123 -> err_cnt=1, pass=0; BITMASK_EN: bad_bits = that sample ^ expected.
// - Toggle 0x555/0xAAA with bit 3 stuck high -> err_cnt = words with bit3 expected 0; BITMASK_EN bad_bits=12'h008.
// - Error injected every word for 70000 clks -> err_cnt=16'hFFFF (saturated), pass=0.
// - rst_n low mid-CHECK -> all outputs 0 next edge, no done; next enable rise starts a clean interval.

Source files
------------

// File: rtl/adc_pattern_check_if.sv
// Sample/verdict bundle between the ADC input-test sequencer and adc_pattern_check.
interface adc_pattern_check_if #(
    parameter int DATA_W = 12,
    parameter int ERR_W  = 16,
    parameter int WCNT_W = 32
);
    logic              enable;
    logic [1:0]        pattern_sel;
    logic [DATA_W-1:0] adc_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_cnt;
    logic [WCNT_W-1:0] word_cnt;
    logic [DATA_W-1:0] bad_bits;

    modport master (
        output enable, pattern_sel, adc_data,
        input  busy, done, pass, err_cnt, word_cnt, bad_bits
    );

    modport slave (
        input  enable, pattern_sel, adc_data,
        output busy, done, pass, err_cnt, word_cnt, bad_bits
    );
endinterface

// File: rtl/adc_pattern_check.sv
// ADC test-pattern checker: counts words and mismatches over an enable interval and latches a verdict.
// Optional macro BITMASK_EN accumulates the OR of mismatching bit positions into bad_bits.
module adc_pattern_check #(
    parameter int                DATA_W    = 12,
    parameter int                ERR_W     = 16,
    parameter int                WCNT_W    = 32,
    parameter logic [DATA_W-1:0] FIXED_PAT = 12'hA5A
) (
    input  logic               clk,
    input  logic               rst_n,
    adc_pattern_check_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] PAT_RAMP   = 2'd1;
    localparam logic [1:0] PAT_TOGGLE = 2'd2;

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    function automatic logic [WCNT_W-1:0] sat_inc_word(input logic [WCNT_W-1:0] v);
        return (&v) ? v : v + WCNT_W'(1);
    endfunction

    state_t            state_q, state_d;
    logic              en_q, en_prev_q;
    logic [DATA_W-1:0] d_q;
    logic [1:0]        pat_q, pat_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [WCNT_W-1:0] word_q, word_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cmp_s;
    logic [DATA_W-1:0] cmp_exp_s;
`ifdef BITMASK_EN
    logic [DATA_W-1:0] bad_q, bad_d;
`endif

    // Next-state, expected-value sequencing and counter updates.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        exp_d     = exp_q;
        err_d     = err_q;
        word_d    = word_q;
        pass_d    = pass_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cmp_s     = 1'b0;
        cmp_exp_s = exp_q;
`ifdef BITMASK_EN
        bad_d     = bad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en_q && !en_prev_q) begin
                    pat_d   = bus.pattern_sel;
                    err_d   = '0;
                    word_d  = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef BITMASK_EN
                    bad_d   = '0;
`endif
                    state_d = ST_SYNC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC, ST_CHECK: begin
                if (!en_q) begin
                    // Counts are final here: no compare happens on the closing cycle.
                    pass_d  = (err_q == '0) && (word_q != '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (state_q == ST_SYNC) begin
                    case (pat_q)
                        PAT_RAMP:   exp_d = d_q + DATA_W'(1);
                        PAT_TOGGLE: exp_d = ~d_q;
                        default: begin
                            cmp_s     = 1'b1;
                            cmp_exp_s = FIXED_PAT;
                            exp_d     = FIXED_PAT;
                        end
                    endcase
                    state_d = ST_CHECK;
                end else begin
                    cmp_s = 1'b1;
                    case (pat_q)
                        PAT_RAMP:   exp_d = exp_q + DATA_W'(1);
                        PAT_TOGGLE: exp_d = ~exp_q;
                        default:    exp_d = exp_q;
                    endcase
                    state_d = ST_CHECK;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (cmp_s) begin
            word_d = sat_inc_word(word_q);
            if (d_q != cmp_exp_s) begin
                err_d = sat_inc_err(err_q);
            end else begin
                err_d = err_q;
            end
`ifdef BITMASK_EN
            bad_d = bad_q | (d_q ^ cmp_exp_s);
`endif
        end else begin
            word_d = word_d;
        end
    end

    // State, input stage and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            en_prev_q <= 1'b0;
            d_q       <= '0;
            pat_q     <= 2'd0;
            exp_q     <= '0;
            err_q     <= '0;
            word_q    <= '0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BITMASK_EN
            bad_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            en_q      <= bus.enable;
            en_prev_q <= en_q;
            d_q       <= bus.adc_data;
            pat_q     <= pat_d;
            exp_q     <= exp_d;
            err_q     <= err_d;
            word_q    <= word_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef BITMASK_EN
            bad_q     <= bad_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.word_cnt = word_q;
`ifdef BITMASK_EN
    assign bus.bad_bits = bad_q;
`else
    assign bus.bad_bits = '0;
`endif
endmodule
